// File: rtl/lnrv_exu_flush_arb.sv
// Fixed-priority flush arbiter between EXU flush sources and the IFU: grants one
// channel, holds its operands until the IFU accepts. Optional LNRV_FLUSH_ARB_CNT_EN
// enables a saturating 16-bit completed-flush counter on flush_cnt.
module lnrv_exu_flush_arb #(
  parameter int CH_NUM = 4,
  parameter int PC_W   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CH_NUM-1:0]        flush_req,
  output logic [CH_NUM-1:0]        flush_ack,
  input  logic [CH_NUM*PC_W-1:0]   flush_pc_op1,
  input  logic [CH_NUM*PC_W-1:0]   flush_pc_op2,
  output logic                     pipe_flush_req,
  input  logic                     pipe_flush_ack,
  output logic [PC_W-1:0]          pipe_flush_pc_op1,
  output logic [PC_W-1:0]          pipe_flush_pc_op2,
  output logic [CH_NUM-1:0]        pipe_flush_src,
  output logic [15:0]              flush_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state;
  logic [CH_NUM-1:0] grant_oh;
  logic [PC_W-1:0]   grant_op1;
  logic [PC_W-1:0]   grant_op2;
  logic              ack_fire;

  // Walk from the top channel down so the lowest asserted index is the last
  // (and therefore winning) assignment.
  // NOTE: every always_comb output gets a default first, otherwise an idle
  // request vector would leave them unassigned and infer latches.
  always_comb begin
    grant_oh  = '0;
    grant_op1 = '0;
    grant_op2 = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (flush_req[i]) begin
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
        grant_op1   = flush_pc_op1[i*PC_W +: PC_W];
        grant_op2   = flush_pc_op2[i*PC_W +: PC_W];
      end
    end
  end

  assign ack_fire = (state == HOLD) && pipe_flush_ack;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      pipe_flush_req    <= 1'b0;
      pipe_flush_pc_op1 <= '0;
      pipe_flush_pc_op2 <= '0;
      pipe_flush_src    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|flush_req) begin
            state             <= HOLD;
            pipe_flush_req    <= 1'b1;
            pipe_flush_pc_op1 <= grant_op1;
            pipe_flush_pc_op2 <= grant_op2;
            pipe_flush_src    <= grant_oh;
          end
        end
        HOLD: begin
          // No preemption: operands and source stay frozen until the IFU accepts.
          if (pipe_flush_ack) begin
            state          <= IDLE;
            pipe_flush_req <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          pipe_flush_req <= 1'b0;
        end
      endcase
    end
  end

  // Reset gates the ack so a flush discarded by reset is never acknowledged.
  assign flush_ack = (ack_fire && !reset) ? pipe_flush_src : '0;

`ifdef LNRV_FLUSH_ARB_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'h0000;
    end else if (ack_fire && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign flush_cnt = cnt_q;
`else
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: doc/lnrv_exu_flush_arb.md
LNRV_EXU_FLUSH_ARB -- requirements
Module: lnrv_exu_flush_arb

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of flush request channels (2..8).
REQ-002 SHALL have parameter PC_W, default 32, width of each PC operand.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush_req  input  CH_NUM  per-channel flush request; bit 0 has the highest priority.
REQ-006 SHALL have port flush_ack  output  CH_NUM  per-channel one-cycle acknowledge.
REQ-007 SHALL have port flush_pc_op1  input  CH_NUM*PC_W  packed operand 1; channel i occupies bits [i*PC_W +: PC_W].
REQ-008 SHALL have port flush_pc_op2  input  CH_NUM*PC_W  packed operand 2, packed the same way as operand 1.
REQ-009 SHALL have port pipe_flush_req  output  1  registered flush request to the IFU.
REQ-010 SHALL have port pipe_flush_ack  input  1  IFU acceptance of the flush.
REQ-011 SHALL have ports pipe_flush_pc_op1 and pipe_flush_pc_op2  output  PC_W each  registered operands of the granted channel.
REQ-012 SHALL have port pipe_flush_src  output  CH_NUM  one-hot identifier of the granted channel.
REQ-013 SHALL have port flush_cnt  output  16  count of completed flushes (see Configuration).

Function
REQ-014 SHALL implement a two-state FSM with states IDLE and HOLD.
REQ-015 In IDLE with flush_req nonzero, SHALL grant the lowest-index asserted channel.
- On that grant it SHALL latch the granted channel's op1, op2 and one-hot source.
- It SHALL then enter HOLD on the next edge.
REQ-016 In IDLE with flush_req zero, SHALL remain in IDLE and latch nothing.
REQ-017 SHALL assert pipe_flush_req exactly while in HOLD, giving 1-cycle latency from request to pipe_flush_req.
REQ-018 In HOLD, pipe_flush_pc_op1, pipe_flush_pc_op2 and pipe_flush_src SHALL stay stable until acknowledged.
REQ-019 In HOLD with pipe_flush_ack=1, SHALL combinationally drive flush_ack=pipe_flush_src for that cycle and return to IDLE.
REQ-020 In HOLD with pipe_flush_ack=0, SHALL stay in HOLD with all flush_ack bits 0.
REQ-021 SHALL hold flush_ack at 0 in IDLE, and pipe_flush_ack in IDLE SHALL have no effect.
REQ-022 Once granted, SHALL NOT preempt.
- A higher-priority request arriving during HOLD waits until the next IDLE arbitration.
REQ-023 If the granted channel deasserts flush_req during HOLD, SHALL still complete the latched flush and pulse its ack.
REQ-024 SHALL re-arbitrate only in IDLE, giving at most one flush per two cycles.
- The acked requester is expected to drop its request in the ack cycle.

Reset
REQ-025 While reset=1, SHALL force state to IDLE.
REQ-026 While reset=1, SHALL drive pipe_flush_req=0, pipe_flush_pc_op1=0, pipe_flush_pc_op2=0, pipe_flush_src=0, flush_ack=0 and flush_cnt=0.
REQ-027 Reset asserted during HOLD SHALL discard the pending flush without issuing any flush_ack.
- Arbitration SHALL resume in the first cycle after reset deasserts.

Configuration
REQ-028 With macro LNRV_FLUSH_ARB_CNT_EN defined, flush_cnt SHALL be a 16-bit register.
- It SHALL increment by 1 on each HOLD cycle with pipe_flush_ack=1.
- It SHALL saturate at 16'hFFFF (no wrap).
REQ-029 Without LNRV_FLUSH_ARB_CNT_EN, flush_cnt SHALL be tied to 16'h0000 and no counter logic SHALL exist.

Verification
REQ-030 Single flush on channel 2, CH_NUM=4:
- Stimulus: flush_req=4'b0100, op1=32'h8000_0000, op2=32'h10 at cycle 0; pipe_flush_ack=1 at cycle 3.
- Response: pipe_flush_req=1 on cycles 1-3, src=4'b0100, operands as given; flush_ack=4'b0100 on cycle 3 only.
REQ-031 Simultaneous requests:
- Stimulus: flush_req=4'b1011.
- Response: channel 0 granted first; after its ack, channel 1, then channel 3; each pulses its ack once.
REQ-032 No preemption:
- Stimulus: channel 3 in HOLD; flush_req[0] asserts; ack held 0 for 5 cycles.
- Response: src stays 4'b1000 and operands are unchanged until ack; channel 0 is granted in the next IDLE.
REQ-033 Reset mid-flush:
- Stimulus: reset=1 during HOLD for channel 1.
- Response: next cycle pipe_flush_req=0, flush_ack=0, src=0; channel 1 receives no ack.
REQ-034 Counter saturation, macro defined:
- Stimulus: force the counter to 16'hFFFE, then complete 3 flushes.
- Response: flush_cnt reads 16'hFFFF and stays there; with the macro undefined, flush_cnt stays 0.
